// File: rtl/pe_traffic_node.sv
// Per-node mesh traffic generator: injects PKT_COUNT packets to every other node
// in raster order on the PE port and counts/checks packets ejected to this node.
module pe_traffic_node #(
    parameter int          DATA_WIDTH      = 64,
    parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
    parameter int          MESH_X          = 2,
    parameter int          MESH_Y          = 2,
    parameter int          PKT_COUNT       = 1,
    parameter int          GAP             = 0,
    parameter int          SINK_STALL      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  start,
    output logic                  pesi,
    output logic [DATA_WIDTH-1:0] pedi,
    input  logic                  peri,
    input  logic                  peso,
    input  logic [DATA_WIDTH-1:0] pedo,
    output logic                  pero,
    output logic                  done,
    output logic [15:0]           sent_count,
    output logic [15:0]           recv_count,
    output logic [15:0]           err_count
);

    localparam int          PW       = DATA_WIDTH - 32;
    localparam logic [7:0]  OWN_X    = CURRENT_ADDRESS[15:8];
    localparam logic [7:0]  OWN_Y    = CURRENT_ADDRESS[7:0];
    localparam logic [7:0]  X_LAST   = 8'(MESH_X - 1);
    localparam logic [7:0]  Y_LAST   = 8'(MESH_Y - 1);
    localparam logic [8:0]  X_LIM    = 9'(MESH_X);
    localparam logic [8:0]  Y_LIM    = 9'(MESH_Y);
    localparam logic [7:0]  PKT_LAST = 8'(PKT_COUNT - 1);
    localparam logic [7:0]  GAP_INIT = 8'(GAP - 1);
    localparam bit          HAS_DEST = (MESH_X * MESH_Y > 1) && (PKT_COUNT > 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t      state;
    logic [7:0]  dst_x, dst_y;
    logic [7:0]  pkt_idx;
    logic [7:0]  gap_cnt;
    logic [15:0] seq;

    // Next raster destination after (x,y), skipping our own address.
    // Bit 16 flags that the walk ran off the end of the mesh.
    function automatic logic [16:0] next_dst(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] nx, ny;
        logic       fin;
        nx  = x;
        ny  = y;
        fin = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!fin && (k == 0 || {nx, ny} == CURRENT_ADDRESS)) begin
                if (nx == X_LAST) begin
                    nx = 8'h00;
                    if (ny == Y_LAST) fin = 1'b1;
                    else              ny = ny + 8'd1;
                end else begin
                    nx = nx + 8'd1;
                end
            end
        end
        return {fin, nx, ny};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] build_flit(input logic [7:0]  x,
                                                         input logic [7:0]  y,
                                                         input logic [15:0] sq,
                                                         input logic        vc);
        logic [7:0]    adx, ady;
        logic [PW-1:0] pl;
        adx = (x > OWN_X) ? x - OWN_X : OWN_X - x;
        ady = (y > OWN_Y) ? y - OWN_Y : OWN_Y - y;
        pl  = '0;
        pl[31:0] = {x, y, sq};
        return {vc, x > OWN_X, y > OWN_Y, 5'b0, adx[3:0], ady[3:0], CURRENT_ADDRESS, pl};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [16:0] first_d, nd;
    logic        pkt_wrap, last_pkt, start_ok;
    logic [7:0]  nxt_x, nxt_y;
    logic [15:0] seq_inc;

    assign first_d  = (CURRENT_ADDRESS == 16'h0000) ? next_dst(8'h00, 8'h00) : 17'h0;
    assign nd       = next_dst(dst_x, dst_y);
    assign pkt_wrap = (pkt_idx == PKT_LAST);
    assign last_pkt = pkt_wrap && nd[16];
    assign nxt_x    = pkt_wrap ? nd[15:8] : dst_x;
    assign nxt_y    = pkt_wrap ? nd[7:0]  : dst_y;
    assign seq_inc  = seq + 16'd1;
    assign start_ok = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pesi       <= 1'b0;
            pedi       <= '0;
            done       <= 1'b0;
            sent_count <= 16'h0;
            seq        <= 16'h0;
            dst_x      <= 8'h0;
            dst_y      <= 8'h0;
            pkt_idx    <= 8'h0;
            gap_cnt    <= 8'h0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sent_count <= 16'h0;
                        seq        <= 16'h0;
                        pkt_idx    <= 8'h0;
                        if (HAS_DEST) begin
                            dst_x <= first_d[15:8];
                            dst_y <= first_d[7:0];
                            pedi  <= build_flit(first_d[15:8], first_d[7:0], 16'h0, polarity);
                            pesi  <= 1'b1;
                            done  <= 1'b0;
                            state <= S_SEND;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_SEND: begin
                    if (peri) begin
                        sent_count <= sat_inc(sent_count);
                        seq        <= seq_inc;
                        pkt_idx    <= pkt_wrap ? 8'h0 : pkt_idx + 8'd1;
                        dst_x      <= nxt_x;
                        dst_y      <= nxt_y;
                        if (last_pkt) begin
                            pesi  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (GAP == 0) begin
                            pedi <= build_flit(nxt_x, nxt_y, seq_inc, polarity);
                        end else begin
                            pesi    <= 1'b0;
                            gap_cnt <= GAP_INIT;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // Destination and seq were already advanced at the handshake.
                    if (gap_cnt == 8'h0) begin
                        pesi  <= 1'b1;
                        pedi  <= build_flit(dst_x, dst_y, seq, polarity);
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic        rx, rx_bad;
    logic [15:0] rx_src, rx_dst;
    logic        rx_unused;

    assign rx        = peso & pero;
    assign rx_src    = pedo[DATA_WIDTH-17 -: 16];
    assign rx_dst    = pedo[31:16];
    assign rx_bad    = (rx_dst != CURRENT_ADDRESS)
                     || ({1'b0, rx_src[15:8]} >= X_LIM)
                     || ({1'b0, rx_src[7:0]} >= Y_LIM)
                     || (rx_src == CURRENT_ADDRESS);
    assign rx_unused = ^{pedo, first_d[16]};

    // A receive on the start cycle lands after the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            recv_count <= 16'h0;
            err_count  <= 16'h0;
        end else if (start_ok) begin
            recv_count <= {15'h0, rx};
            err_count  <= {15'h0, rx & rx_bad};
        end else if (rx) begin
            recv_count <= sat_inc(recv_count);
            if (rx_bad) err_count <= sat_inc(err_count);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pero <= 1'b0;
        else        pero <= (SINK_STALL != 0) ? ~pero : 1'b1;
    end

endmodule

// File: tb/tb_pe_traffic_node.sv
// Bench for pe_traffic_node: three instances (2x2 node 0, 2x2 node 0101 with gap and
// sink stall, 1x1) driven from one sequence; injected flits checked via scoreboards.
module tb_pe_traffic_node;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, pol_a, start_a, pesi_a, peri_a, peso_a, pero_a, done_a;
    logic [63:0] pedi_a, pedo_a;
    logic [15:0] sent_a, recv_a, err_a;
    logic        rst_b, pol_b, start_b, pesi_b, peri_b, peso_b, pero_b, done_b;
    logic [63:0] pedi_b, pedo_b;
    logic [15:0] sent_b, recv_b, err_b;
    logic        rst_c, pol_c, start_c, pesi_c, peri_c, peso_c, pero_c, done_c;
    logic [63:0] pedi_c, pedo_c;
    logic [15:0] sent_c, recv_c, err_c;

    pe_traffic_node #(.DATA_WIDTH(64), .CURRENT_ADDRESS(16'h0000), .MESH_X(2), .MESH_Y(2),
                      .PKT_COUNT(1), .GAP(0), .SINK_STALL(0)) u_a (
        .clk(clk), .reset(rst_a), .polarity(pol_a), .start(start_a),
        .pesi(pesi_a), .pedi(pedi_a), .peri(peri_a), .peso(peso_a), .pedo(pedo_a),
        .pero(pero_a), .done(done_a), .sent_count(sent_a), .recv_count(recv_a),
        .err_count(err_a));

    pe_traffic_node #(.DATA_WIDTH(64), .CURRENT_ADDRESS(16'h0101), .MESH_X(2), .MESH_Y(2),
                      .PKT_COUNT(1), .GAP(2), .SINK_STALL(1)) u_b (
        .clk(clk), .reset(rst_b), .polarity(pol_b), .start(start_b),
        .pesi(pesi_b), .pedi(pedi_b), .peri(peri_b), .peso(peso_b), .pedo(pedo_b),
        .pero(pero_b), .done(done_b), .sent_count(sent_b), .recv_count(recv_b),
        .err_count(err_b));

    pe_traffic_node #(.DATA_WIDTH(64), .CURRENT_ADDRESS(16'h0000), .MESH_X(1), .MESH_Y(1),
                      .PKT_COUNT(1), .GAP(0), .SINK_STALL(0)) u_c (
        .clk(clk), .reset(rst_c), .polarity(pol_c), .start(start_c),
        .pesi(pesi_c), .pedi(pedi_c), .peri(peri_c), .peso(peso_c), .pedo(pedo_c),
        .pero(pero_c), .done(done_c), .sent_count(sent_c), .recv_count(recv_c),
        .err_count(err_c));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    bit          c_pesi_seen = 1'b0;

    // Scoreboards: a flit is checked when pesi&peri will handshake on the next edge.
    always @(negedge clk) begin
        #2;
        if (pesi_a === 1'b1 && peri_a === 1'b1) begin
            if (q_a.size() == 0) chk("a_unexpected_flit", pedi_a, 64'hX);
            else                 chk("a_flit", pedi_a, q_a.pop_front());
        end
        if (pesi_b === 1'b1 && peri_b === 1'b1) begin
            if (q_b.size() == 0) chk("b_unexpected_flit", pedi_b, 64'hX);
            else                 chk("b_flit", pedi_b, q_b.pop_front());
        end
        if (pesi_c === 1'b1) c_pesi_seen = 1'b1;
    end

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] exp_recv;
        logic [15:0] exp_err;
    } rx_vec_t;

    rx_vec_t     rxv[6];
    bit          exp_pesi_b[8];
    logic [63:0] good_a;
    int          k;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rxv[0] = '{16'h0100, 16'h0000, 16'd1, 16'd0};
        rxv[1] = '{16'h0100, 16'h0001, 16'd2, 16'd1};
        rxv[2] = '{16'h0200, 16'h0000, 16'd3, 16'd2};
        rxv[3] = '{16'h0000, 16'h0000, 16'd4, 16'd3};
        rxv[4] = '{16'h0101, 16'h0000, 16'd5, 16'd3};
        rxv[5] = '{16'h0002, 16'h0000, 16'd6, 16'd4};
        exp_pesi_b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        good_a = {16'h0, 16'h0100, 16'h0000, 16'h0};

        rst_a = 0; pol_a = 1; start_a = 0; peri_a = 0; peso_a = 0; pedo_a = '0;
        rst_b = 0; pol_b = 0; start_b = 0; peri_b = 0; peso_b = 0; pedo_b = '0;
        rst_c = 0; pol_c = 0; start_c = 0; peri_c = 0; peso_c = 0; pedo_c = '0;
        repeat (3) @(negedge clk);

        chk("a_rst_pesi", pesi_a, 0);
        chk("a_rst_pedi", pedi_a, 0);
        chk("a_rst_pero", pero_a, 0);
        chk("a_rst_done", done_a, 0);
        chk("a_rst_sent", sent_a, 0);
        chk("a_rst_recv", recv_a, 0);
        chk("a_rst_err", err_a, 0);
        chk("b_rst_pero", pero_b, 0);

        rst_a = 1; rst_b = 1; rst_c = 1;
        @(negedge clk);
        chk("a_pero_up", pero_a, 1);
        chk("b_pero_up", pero_b, 1);
        @(negedge clk);
        chk("a_pero_steady", pero_a, 1);
        chk("b_pero_toggle", pero_b, 0);

        // Receive checker vectors
        for (int i = 0; i < 6; i++) begin
            peso_a = 1;
            pedo_a = {16'h0, rxv[i].src, rxv[i].dst, 16'h0};
            @(negedge clk);
            peso_a = 0;
            chk($sformatf("a_rx%0d_recv", i), recv_a, rxv[i].exp_recv);
            chk($sformatf("a_rx%0d_err", i), err_a, rxv[i].exp_err);
        end

        // Full run from node 0, start coinciding with a good receive
        peri_a = 1; start_a = 1; peso_a = 1; pedo_a = good_a;
        q_a.push_back(64'hC010_0000_0100_0000);
        q_a.push_back(64'hA001_0000_0001_0001);
        q_a.push_back(64'hE011_0000_0101_0002);
        @(negedge clk);
        start_a = 0; peso_a = 0;
        chk("a_start_recv", recv_a, 1);
        chk("a_start_err", err_a, 0);
        chk("a_pesi_c1", pesi_a, 1);
        @(negedge clk);
        chk("a_pesi_c2", pesi_a, 1);
        @(negedge clk);
        chk("a_pesi_c3", pesi_a, 1);
        @(negedge clk);
        chk("a_done", done_a, 1);
        chk("a_pesi_after", pesi_a, 0);
        chk("a_sent", sent_a, 3);
        chk("a_q_empty", 64'(q_a.size()), 0);

        // Back-pressure: peri low for 5 cycles of the first SEND
        peri_a = 0; start_a = 1;
        q_a.push_back(64'hC010_0000_0100_0000);
        q_a.push_back(64'hA001_0000_0001_0001);
        q_a.push_back(64'hE011_0000_0101_0002);
        @(negedge clk);
        start_a = 0;
        chk("a_done_cleared", done_a, 0);
        for (int i = 0; i < 5; i++) begin
            chk("a_stall_pesi", pesi_a, 1);
            chk("a_stall_pedi", pedi_a, 64'hC010_0000_0100_0000);
            chk("a_stall_sent", sent_a, 0);
            if (i < 4) @(negedge clk);
        end
        peri_a = 1;
        k = 0;
        while (done_a !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("a_stall_done", done_a, 1);
        chk("a_stall_sent_final", sent_a, 3);
        chk("a_stall_q_empty", 64'(q_a.size()), 0);

        // Asynchronous reset mid-run
        start_a = 1;
        q_a.push_back(64'hC010_0000_0100_0000);
        q_a.push_back(64'hA001_0000_0001_0001);
        q_a.push_back(64'hE011_0000_0101_0002);
        @(negedge clk);
        start_a = 0;
        @(negedge clk);
        chk("a_prereset_pesi", pesi_a, 1);
        chk("a_prereset_sent", sent_a, 1);
        #4 rst_a = 0;
        #1;
        chk("a_midrst_pesi", pesi_a, 0);
        chk("a_midrst_pedi", pedi_a, 0);
        chk("a_midrst_sent", sent_a, 0);
        chk("a_midrst_recv", recv_a, 0);
        chk("a_midrst_done", done_a, 0);
        q_a.delete();
        peri_a = 0;
        @(negedge clk);
        rst_a = 1;

        // Counter saturation
        @(negedge clk);
        peso_a = 1; pedo_a = good_a;
        repeat (70000) @(negedge clk);
        peso_a = 0;
        chk("a_recv_sat", recv_a, 16'hFFFF);
        chk("a_err_sat_zero", err_a, 0);

        // Node 0101: sink stall halves acceptance
        peso_b = 1; pedo_b = {16'h0, 16'h0000, 16'h0101, 16'h0};
        repeat (6) @(negedge clk);
        peso_b = 0;
        chk("b_stall_recv", recv_b, 3);
        chk("b_stall_err", err_b, 0);

        // Node 0101 run with GAP=2
        peri_b = 1; start_b = 1;
        q_b.push_back(64'h0011_0101_0000_0000);
        q_b.push_back(64'h0001_0101_0100_0001);
        q_b.push_back(64'h0010_0101_0001_0002);
        @(negedge clk);
        start_b = 0;
        chk("b_recv_cleared", recv_b, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b_pesi_c%0d", i + 1), pesi_b, exp_pesi_b[i]);
            if (i < 7) @(negedge clk);
        end
        chk("b_done", done_b, 1);
        chk("b_sent", sent_b, 3);
        chk("b_q_empty", 64'(q_b.size()), 0);

        // 1x1 mesh: nothing to send
        start_c = 1;
        @(negedge clk);
        start_c = 0;
        chk("c_done", done_c, 1);
        chk("c_sent", sent_c, 0);
        repeat (3) @(negedge clk);
        chk("c_pesi_never", 64'(c_pesi_seen), 0);
        chk("c_done_holds", done_c, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
